// File: rtl/pe_pkg.sv
// Shared defaults and arithmetic helpers for the row-stationary convolution PE.
// Sizes the partial sum and clamps wide sums to a chosen width.
package pe_pkg;

  localparam int DEF_DW  = 8;
  localparam int DEF_K   = 3;
  localparam int CLAMP_W = 64;

  // Two guard bits above the product width hold the sum of the default tap count.
  function automatic int psum_width(input int dw);
    return 2 * dw + 2;
  endfunction

  function automatic logic [CLAMP_W-1:0] sat_clamp(input logic [CLAMP_W-1:0] val, input int w);
    logic [CLAMP_W-1:0] max_v;
    max_v = (CLAMP_W'(1) << w) - CLAMP_W'(1);
    return (val > max_v) ? max_v : val;
  endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Combinational K-product adder plus optional incoming partial sum, clamped to PW bits.
// No state and no flow control; the enclosing pipeline registers its output.
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int K  = DEF_K,
  parameter int PW = psum_width(DEF_DW)
) (
  input  logic [K-1:0][2*DW-1:0] prod,
  input  logic                   psum_sel,
  input  logic [PW-1:0]          psum_in,
  output logic [PW-1:0]          sum
);

  // One extra bit absorbs the psum addition before the clamp.
  logic [PW:0] acc;

  always_comb begin
    acc = '0;
    for (int j = 0; j < K; j++) begin
      acc = acc + (PW+1)'(prod[j]);
    end
    if (psum_sel) begin
      acc = acc + {1'b0, psum_in};
    end
    sum = PW'(sat_clamp(CLAMP_W'(acc), PW));
  end

endmodule

// File: rtl/pe_row_conv.sv
// K-tap row convolution PE: window reg (S1), products (S2), clamped output (S3); 2 edges window-beat to out_valid.
// out_valid && !out_ready freezes every stage, the window and the fill count, and drops act_ready.
module pe_row_conv
  import pe_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int K  = DEF_K,
  parameter int PW = psum_width(DW)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  w_load,
  input  logic [$clog2(K)-1:0]  w_idx,
  input  logic [DW-1:0]         w_data,
  input  logic                  act_valid,
  output logic                  act_ready,
  input  logic [DW-1:0]         act_data,
  input  logic                  act_last,
  input  logic                  psum_sel,
  input  logic [PW-1:0]         psum_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PW-1:0]         out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int IW = $clog2(K);
  localparam int CW = $clog2(K + 1);

  logic [K-1:0][DW-1:0]   w_q, w_d, win_q, win_d, s1_win_q, s1_win_d, win_shift;
  logic [CW-1:0]          fill_q, fill_d;
  logic                   s1_vld_q, s1_vld_d, s1_last_q, s1_last_d, s1_sel_q, s1_sel_d;
  logic [PW-1:0]          s1_psum_q, s1_psum_d;
  logic                   s2_vld_q, s2_vld_d, s2_last_q, s2_last_d, s2_sel_q, s2_sel_d;
  logic [PW-1:0]          s2_psum_q, s2_psum_d;
  logic [K-1:0][2*DW-1:0] s2_prod_q, s2_prod_d;
  logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [PW-1:0]          out_data_q, out_data_d;
  logic                   stall, accept, win_beat;
  logic [PW-1:0]          sum;

  assign stall     = out_valid_q && !out_ready;
  assign act_ready = !stall;
  assign accept    = act_valid && act_ready;
  assign win_beat  = fill_q >= CW'(K - 1);
  assign busy      = s1_vld_q || s2_vld_q || out_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  always_comb begin
    for (int j = 0; j < K - 1; j++) begin
      win_shift[j] = win_q[j+1];
    end
    win_shift[K-1] = act_data;
  end

  always_comb begin
    w_d         = w_q;
    win_d       = win_q;
    fill_d      = fill_q;
    s1_vld_d    = s1_vld_q;
    s1_win_d    = s1_win_q;
    s1_last_d   = s1_last_q;
    s1_sel_d    = s1_sel_q;
    s1_psum_d   = s1_psum_q;
    s2_vld_d    = s2_vld_q;
    s2_prod_d   = s2_prod_q;
    s2_last_d   = s2_last_q;
    s2_sel_d    = s2_sel_q;
    s2_psum_d   = s2_psum_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    // Indices at or above K match no tap, so such writes fall away.
    if (w_load && !busy) begin
      for (int j = 0; j < K; j++) begin
        if (w_idx == IW'(j)) w_d[j] = w_data;
      end
    end

    if (accept) begin
      win_d  = act_last ? '0 : win_shift;
      fill_d = act_last ? '0 : ((fill_q == CW'(K)) ? fill_q : fill_q + CW'(1));
    end

    if (!stall) begin
      s1_vld_d = accept && win_beat;
      if (accept) begin
        s1_win_d  = win_shift;
        s1_last_d = act_last;
        s1_sel_d  = psum_sel;
        s1_psum_d = psum_in;
      end
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        for (int j = 0; j < K; j++) begin
          s2_prod_d[j] = (2*DW)'(w_q[j]) * (2*DW)'(s1_win_q[j]);
        end
        s2_last_d = s1_last_q;
        s2_sel_d  = s1_sel_q;
        s2_psum_d = s1_psum_q;
      end
      out_valid_d = s2_vld_q;
      if (s2_vld_q) begin
        out_data_d = sum;
        out_last_d = s2_last_q;
      end
    end
  end

  pe_sat_add #(.DW(DW), .K(K), .PW(PW)) u_sat_add (
    .prod     (s2_prod_q),
    .psum_sel (s2_sel_q),
    .psum_in  (s2_psum_q),
    .sum      (sum)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q         <= '0;
      win_q       <= '0;
      fill_q      <= '0;
      s1_vld_q    <= 1'b0;
      s1_win_q    <= '0;
      s1_last_q   <= 1'b0;
      s1_sel_q    <= 1'b0;
      s1_psum_q   <= '0;
      s2_vld_q    <= 1'b0;
      s2_prod_q   <= '0;
      s2_last_q   <= 1'b0;
      s2_sel_q    <= 1'b0;
      s2_psum_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      w_q         <= w_d;
      win_q       <= win_d;
      fill_q      <= fill_d;
      s1_vld_q    <= s1_vld_d;
      s1_win_q    <= s1_win_d;
      s1_last_q   <= s1_last_d;
      s1_sel_q    <= s1_sel_d;
      s1_psum_q   <= s1_psum_d;
      s2_vld_q    <= s2_vld_d;
      s2_prod_q   <= s2_prod_d;
      s2_last_q   <= s2_last_d;
      s2_sel_q    <= s2_sel_d;
      s2_psum_q   <= s2_psum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_pe_row_conv.sv
// Bench for pe_row_conv: table of rows with hand-derived results, scoreboard queue, and
// hand sequences for latency, backpressure, weight writes while busy, and async reset.
module tb_pe_row_conv;
  import pe_pkg::*;

  localparam int DW = 8;
  localparam int K  = 3;
  localparam int PW = 18;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          w_load;
  logic [1:0]    w_idx;
  logic [DW-1:0] w_data;
  logic          act_valid, act_ready, act_last;
  logic [DW-1:0] act_data;
  logic          psum_sel;
  logic [PW-1:0] psum_in;
  logic          out_valid, out_ready, out_last, busy;
  logic [PW-1:0] out_data;

  pe_row_conv #(.DW(DW), .K(K), .PW(PW)) dut (
    .clk(clk), .reset_n(reset_n), .w_load(w_load), .w_idx(w_idx), .w_data(w_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data), .act_last(act_last),
    .psum_sel(psum_sel), .psum_in(psum_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned data;
    bit          last;
  } exp_t;

  typedef struct {
    int unsigned w[3];
    int          n;
    int unsigned a[6];
    bit          sel;
    int unsigned psum;
    int          ne;
    int unsigned e[2];
    bit          el[2];
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Scoreboard: a result is taken on the edge following a negedge that sees valid && ready.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0d last %0d, required no output", out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_last", out_last, e.last);
      end
    end
  end

  // All tasks below are entered and left 1 time unit after a rising edge.
  task automatic send_beat(input int unsigned d, input bit l, input bit s, input int unsigned p);
    int n;
    act_valid = 1'b1;
    act_data  = DW'(d);
    act_last  = l;
    psum_sel  = s;
    psum_in   = PW'(p);
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (act_ready) break;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL act_ready_timeout: got 0 for 200 cycles, required 1");
    end
    @(posedge clk);
    #1;
    act_valid = 1'b0;
  endtask

  task automatic send_row(input int unsigned a[6], input int n, input bit s, input int unsigned p);
    for (int i = 0; i < n; i++) send_beat(a[i], i == n - 1, s, p);
  endtask

  task automatic load_w(input int idx, input int unsigned d);
    w_load = 1'b1;
    w_idx  = 2'(idx);
    w_data = DW'(d);
    @(posedge clk);
    #1;
    w_load = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Reference convolution for a longer row; results are queued as beats are driven.
  task automatic send_row_model(input int unsigned w[3], input int n, input int unsigned base);
    int unsigned win[3];
    int          fill;
    int unsigned a, s;
    win  = '{0, 0, 0};
    fill = 0;
    for (int i = 0; i < n; i++) begin
      a      = (base + 37 * i) % 256;
      win[0] = win[1];
      win[1] = win[2];
      win[2] = a;
      fill   = (fill < 3) ? fill + 1 : 3;
      if (fill == 3) begin
        s = w[0] * win[0] + w[1] * win[1] + w[2] * win[2];
        exp_q.push_back('{data: s, last: (i == n - 1)});
      end
      send_beat(a, i == n - 1, 1'b0, 0);
    end
  endtask

  vec_t        vecs[7];
  int unsigned row[6];
  int unsigned tw[3];
  logic [PW-1:0] held;

  initial begin
    vecs[0] = '{w:'{1,2,3}, n:5, a:'{1,2,3,4,5,0}, sel:1'b0, psum:0, ne:2, e:'{14,20}, el:'{1'b0,1'b0}};
    vecs[1] = '{w:'{1,1,1}, n:2, a:'{7,7,0,0,0,0}, sel:1'b0, psum:0, ne:0, e:'{0,0}, el:'{1'b0,1'b0}};
    vecs[2] = '{w:'{1,1,1}, n:3, a:'{1,1,1,0,0,0}, sel:1'b0, psum:0, ne:1, e:'{3,0}, el:'{1'b1,1'b0}};
    vecs[3] = '{w:'{255,255,255}, n:3, a:'{255,255,255,0,0,0}, sel:1'b1, psum:262143, ne:1, e:'{262143,0}, el:'{1'b1,1'b0}};
    vecs[4] = '{w:'{255,255,255}, n:3, a:'{255,255,255,0,0,0}, sel:1'b0, psum:262143, ne:1, e:'{195075,0}, el:'{1'b1,1'b0}};
    vecs[5] = '{w:'{2,0,1}, n:4, a:'{10,20,30,40,0,0}, sel:1'b1, psum:100, ne:2, e:'{150,180}, el:'{1'b0,1'b1}};
    vecs[6] = '{w:'{3,5,7}, n:3, a:'{4,5,6,0,0,0}, sel:1'b0, psum:0, ne:1, e:'{79,0}, el:'{1'b1,1'b0}};

    reset_n   = 1'b1;
    w_load    = 1'b0;
    w_idx     = '0;
    w_data    = '0;
    act_valid = 1'b0;
    act_data  = '0;
    act_last  = 1'b0;
    psum_sel  = 1'b0;
    psum_in   = '0;
    out_ready = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_act_ready", act_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Table rows; the first row's third result (26) is the only last-flagged one.
    for (int v = 0; v < 7; v++) begin
      for (int j = 0; j < 3; j++) load_w(j, vecs[v].w[j]);
      for (int j = 0; j < vecs[v].ne; j++) exp_q.push_back('{data: vecs[v].e[j], last: vecs[v].el[j]});
      if (v == 0) exp_q.push_back('{data: 26, last: 1'b1});
      send_row(vecs[v].a, vecs[v].n, vecs[v].sel, vecs[v].psum);
      drain();
    end

    // Latency: window beat accepted at E0, out_valid visible after E0+2.
    for (int j = 0; j < 3; j++) load_w(j, j + 1);
    exp_q.push_back('{data: 14, last: 1'b1});
    send_beat(1, 1'b0, 1'b0, 0);
    send_beat(2, 1'b0, 1'b0, 0);
    act_valid = 1'b1;
    act_data  = 8'd3;
    act_last  = 1'b1;
    @(negedge clk);
    check("lat_act_ready", act_ready, 1);
    @(posedge clk);
    #1;
    act_valid = 1'b0;
    act_last  = 1'b0;
    @(negedge clk);
    check("lat_e0_valid", out_valid, 0);
    @(negedge clk);
    check("lat_e1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_e2_valid", out_valid, 1);
    drain();

    // Backpressure: four stalled edges in the middle of a 12-beat row.
    tw = '{1, 2, 3};
    fork
      send_row_model(tw, 12, 3);
      begin : stall_proc
        int k;
        for (k = 0; k < 100; k++) begin
          @(posedge clk);
          #1;
          if (out_valid) break;
        end
        check("bp_seen_valid", out_valid, 1);
        out_ready = 1'b0;
        held      = out_data;
        repeat (4) begin
          @(negedge clk);
          check("bp_act_ready", act_ready, 0);
          check("bp_out_valid", out_valid, 1);
          check("bp_out_data_stable", out_data, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Weight write while busy must be dropped; idle writes land; index 3 is ignored.
    for (int j = 0; j < 3; j++) load_w(j, 1);
    row = '{2, 2, 2, 2, 0, 0};
    exp_q.push_back('{data: 6, last: 1'b0});
    exp_q.push_back('{data: 6, last: 1'b1});
    fork
      send_row(row, 4, 1'b0, 0);
      begin : busy_write
        int k;
        for (k = 0; k < 100; k++) begin
          @(posedge clk);
          #1;
          if (busy) break;
        end
        check("wb_busy", busy, 1);
        w_load = 1'b1;
        w_idx  = 2'd0;
        w_data = 8'd9;
        @(posedge clk);
        #1;
        w_load = 1'b0;
      end
    join
    drain();
    row = '{1, 2, 3, 0, 0, 0};
    exp_q.push_back('{data: 6, last: 1'b1});
    send_row(row, 3, 1'b0, 0);
    drain();
    load_w(0, 9);
    exp_q.push_back('{data: 14, last: 1'b1});
    send_row(row, 3, 1'b0, 0);
    drain();
    load_w(3, 50);
    exp_q.push_back('{data: 14, last: 1'b1});
    send_row(row, 3, 1'b0, 0);
    drain();

    // Async reset mid-cycle while a result is held and a row is open.
    for (int j = 0; j < 3; j++) load_w(j, j + 1);
    out_ready = 1'b0;
    send_beat(1, 1'b0, 1'b0, 0);
    send_beat(2, 1'b0, 1'b0, 0);
    send_beat(3, 1'b0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_last", out_last, 0);
    check("arst_busy", busy, 0);
    check("arst_act_ready", act_ready, 1);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    row = '{4, 5, 6, 0, 0, 0};
    exp_q.push_back('{data: 77, last: 1'b1});
    send_row(row, 3, 1'b1, 77);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1);
  end

endmodule
